generation_sequencer: RTL and testbench

Controls one Game-of-Life generation step. It walks `calc_row` 0..ROWS-1 into the line buffer, one row per accept, and counts next-state write-backs until the whole destination frame is written. It then swaps the ping-pong BRAM source select on a video frame boundary, so the display never tears. It sits upstream of the line buffer and is driven by the AXI-Lite pause/run control.

---
 rtl/gol_pkg.sv | 20 ++
 rtl/generation_sequencer.sv | 142 ++++++++++++++
 tb/tb_generation_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// Shared constants and types for the Game-of-Life generation datapath.
package gol_pkg;

  localparam int unsigned ROWS  = 720;
  localparam int unsigned COLS  = 1280;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned GEN_W = 32;
  localparam int unsigned WB_W  = ROW_W + 1;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WAIT_SWAP
  } seq_state_t;

endpackage : gol_pkg

// File: rtl/generation_sequencer.sv
// Sequences one Game-of-Life generation: issues rows to the line buffer, counts
// write-backs, and swaps the ping-pong source buffer on a video frame boundary.
module generation_sequencer
  import gol_pkg::*;
(
  input  logic             out_stream_aclk,
  input  logic             periph_resetn,
  input  logic             run,
  input  logic             step,
  input  logic             frame_sync,
  input  logic             row_ack,
  input  logic             wb_en,
  output logic             calc_flag,
  output logic [ROW_W-1:0] calc_row,
  output logic             src_sel,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             wb_err
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [WB_W-1:0]  WB_FULL  = WB_W'(ROWS);

  seq_state_t       state_q, state_d;
  logic             step_pend_q, step_pend_d;
  logic             calc_flag_q, calc_flag_d;
  logic [ROW_W-1:0] calc_row_q, calc_row_d;
  logic [WB_W-1:0]  wb_cnt_q, wb_cnt_d;
  logic             src_sel_q, src_sel_d;
  logic             busy_q, busy_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             wb_err_q, wb_err_d;
  logic             wb_window;

  assign wb_window = (state_q == ISSUE) || (state_q == DRAIN);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    step_pend_d = step_pend_q;
    calc_flag_d = calc_flag_q;
    calc_row_d  = calc_row_q;
    wb_cnt_d    = wb_cnt_q;
    src_sel_d   = src_sel_q;
    gen_count_d = gen_count_q;
    wb_err_d    = wb_err_q;

    // A write-back is only legal while a generation is draining into the frame.
    if (wb_en) begin
      if (!wb_window || (wb_cnt_q == WB_FULL)) begin
        wb_err_d = 1'b1;
      end else begin
        wb_cnt_d = wb_cnt_q + WB_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (run || step_pend_q) begin
          state_d     = ISSUE;
          step_pend_d = 1'b0;
          calc_flag_d = 1'b1;
          calc_row_d  = '0;
          wb_cnt_d    = '0;
        end else if (step) begin
          step_pend_d = 1'b1;
        end
      end

      ISSUE: begin
        if (row_ack) begin
          if (calc_row_q == LAST_ROW) begin
            state_d     = DRAIN;
            calc_flag_d = 1'b0;
            calc_row_d  = '0;
          end else begin
            calc_row_d = calc_row_q + ROW_W'(1);
          end
        end
      end

      DRAIN: begin
        if (wb_cnt_q == WB_FULL) begin
          state_d = WAIT_SWAP;
        end
      end

      WAIT_SWAP: begin
        if (frame_sync) begin
          src_sel_d   = ~src_sel_q;
          gen_count_d = gen_count_q + GEN_W'(1);
          if (run) begin
            state_d     = ISSUE;
            calc_flag_d = 1'b1;
            calc_row_d  = '0;
            wb_cnt_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q     <= IDLE;
      step_pend_q <= 1'b0;
      calc_flag_q <= 1'b0;
      calc_row_q  <= '0;
      wb_cnt_q    <= '0;
      src_sel_q   <= SRC_A;
      busy_q      <= 1'b0;
      gen_count_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      calc_flag_q <= calc_flag_d;
      calc_row_q  <= calc_row_d;
      wb_cnt_q    <= wb_cnt_d;
      src_sel_q   <= src_sel_d;
      busy_q      <= busy_d;
      gen_count_q <= gen_count_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign calc_flag = calc_flag_q;
  assign calc_row  = calc_row_q;
  assign src_sel   = src_sel_q;
  assign busy      = busy_q;
  assign gen_count = gen_count_q;
  assign wb_err    = wb_err_q;

endmodule : generation_sequencer

// File: tb/tb_generation_sequencer.sv
// Directed scoreboard bench for generation_sequencer.
module tb_generation_sequencer;
  import gol_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run, step, frame_sync, row_ack, wb_en;
  logic             calc_flag;
  logic [ROW_W-1:0] calc_row;
  logic             src_sel, busy, wb_err;
  logic [GEN_W-1:0] gen_count;

  typedef enum int {S_FLAG, S_ROW, S_SRC, S_BUSY, S_GEN, S_ERR} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [2:0]  pipe;

  generation_sequencer dut (
    .out_stream_aclk(clk),
    .periph_resetn  (rst_n),
    .run            (run),
    .step           (step),
    .frame_sync     (frame_sync),
    .row_ack        (row_ack),
    .wb_en          (wb_en),
    .calc_flag      (calc_flag),
    .calc_row       (calc_row),
    .src_sel        (src_sel),
    .busy           (busy),
    .gen_count      (gen_count),
    .wb_err         (wb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_FLAG:  return 32'(calc_flag);
      S_ROW:   return 32'(calc_row);
      S_SRC:   return 32'(src_sel);
      S_BUSY:  return 32'(busy);
      S_GEN:   return 32'(gen_count);
      S_ERR:   return 32'(wb_err);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sig);
      n_vec++;
      assert (o === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic expect_reset(input string tag);
    expect_v({tag, "_flag"}, S_FLAG, 32'd0);
    expect_v({tag, "_row"},  S_ROW,  32'd0);
    expect_v({tag, "_src"},  S_SRC,  32'd0);
    expect_v({tag, "_busy"}, S_BUSY, 32'd0);
    expect_v({tag, "_gen"},  S_GEN,  32'd0);
    expect_v({tag, "_err"},  S_ERR,  32'd0);
  endtask

  // One clock; the write-back stage answers each accepted row three cycles later.
  task automatic tick();
    logic acc;
    acc = row_ack && calc_flag;
    @(posedge clk);
    #1;
    pipe  = {pipe[1:0], acc};
    wb_en = pipe[2];
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; frame_sync = 1'b0;
    row_ack = 1'b0; wb_en = 1'b0; pipe = '0;
    #3;
    expect_reset("por");
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    expect_v("idle_busy", S_BUSY, 32'd0);
    check_all();

    // Generation 1: free-run, one row accepted per cycle.
    run = 1'b1; row_ack = 1'b1;
    tick();
    expect_v("g1_start_flag", S_FLAG, 32'd1);
    expect_v("g1_start_row",  S_ROW,  32'd0);
    expect_v("g1_start_busy", S_BUSY, 32'd1);
    check_all();
    for (int r = 1; r < int'(ROWS); r++) begin
      tick();
      expect_v("g1_row", S_ROW, 32'(r));
      check_all();
    end
    tick();
    row_ack = 1'b0;
    expect_v("g1_end_flag", S_FLAG, 32'd0);
    expect_v("g1_end_row",  S_ROW,  32'd0);
    check_all();
    ticks(6);
    expect_v("g1_wait_busy", S_BUSY, 32'd1);
    expect_v("g1_wait_src",  S_SRC,  32'd0);
    expect_v("g1_wait_err",  S_ERR,  32'd0);
    check_all();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    expect_v("g1_swap_src",  S_SRC,  32'd1);
    expect_v("g1_swap_gen",  S_GEN,  32'd1);
    expect_v("g1_swap_flag", S_FLAG, 32'd1);
    expect_v("g1_swap_row",  S_ROW,  32'd0);
    check_all();

    // Generation 2: run dropped mid-generation; frame_sync on the entry edge is missed.
    run = 1'b0; row_ack = 1'b1;
    ticks(int'(ROWS) - 1);
    expect_v("g2_last_row", S_ROW, 32'(ROWS - 1));
    check_all();
    tick();
    row_ack = 1'b0;
    expect_v("g2_end_flag", S_FLAG, 32'd0);
    check_all();
    ticks(3);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    expect_v("g2_entry_src",  S_SRC,  32'd1);
    expect_v("g2_entry_gen",  S_GEN,  32'd1);
    expect_v("g2_entry_busy", S_BUSY, 32'd1);
    check_all();
    ticks(3);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    expect_v("g2_swap_src",  S_SRC,  32'd0);
    expect_v("g2_swap_gen",  S_GEN,  32'd2);
    expect_v("g2_swap_busy", S_BUSY, 32'd0);
    expect_v("g2_swap_flag", S_FLAG, 32'd0);
    expect_v("g2_swap_err",  S_ERR,  32'd0);
    check_all();
    ticks(3);
    expect_v("g2_stopped_busy", S_BUSY, 32'd0);
    check_all();

    // Generation 3: single step, slow acks, ignored second step, extra write-back.
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_v("g3_pend_busy", S_BUSY, 32'd0);
    check_all();
    tick();
    expect_v("g3_start_busy", S_BUSY, 32'd1);
    expect_v("g3_start_flag", S_FLAG, 32'd1);
    expect_v("g3_start_row",  S_ROW,  32'd0);
    check_all();
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int r = 0; r < int'(ROWS); r++) begin
      ticks(3);
      expect_v("g3_hold_row", S_ROW, 32'(r));
      check_all();
      row_ack = 1'b1;
      tick();
      row_ack = 1'b0;
    end
    expect_v("g3_end_flag", S_FLAG, 32'd0);
    check_all();
    ticks(3);
    wb_en = 1'b1;
    tick();
    expect_v("g3_extra_wb_err", S_ERR, 32'd1);
    check_all();
    ticks(3);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    expect_v("g3_swap_src",  S_SRC,  32'd1);
    expect_v("g3_swap_gen",  S_GEN,  32'd3);
    expect_v("g3_swap_busy", S_BUSY, 32'd0);
    check_all();
    ticks(4);
    expect_v("g3_idle_busy",   S_BUSY, 32'd0);
    expect_v("g3_idle_gen",    S_GEN,  32'd3);
    expect_v("g3_sticky_err",  S_ERR,  32'd1);
    check_all();

    // Asynchronous reset in the middle of a generation.
    run = 1'b1; row_ack = 1'b1;
    ticks(301);
    expect_v("rst_pre_row", S_ROW, 32'd300);
    check_all();
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset("async");
    check_all();
    row_ack = 1'b0; pipe = '0; wb_en = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    tick();
    expect_v("rel_flag", S_FLAG, 32'd1);
    expect_v("rel_row",  S_ROW,  32'd0);
    expect_v("rel_src",  S_SRC,  32'd0);
    expect_v("rel_gen",  S_GEN,  32'd0);
    check_all();

    // Write-back while idle.
    run = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    expect_v("idle2_busy", S_BUSY, 32'd0);
    expect_v("idle2_err",  S_ERR,  32'd0);
    check_all();
    wb_en = 1'b1;
    tick();
    expect_v("idle_wb_err", S_ERR, 32'd1);
    check_all();
    ticks(3);
    expect_v("idle_wb_err_sticky", S_ERR,  32'd1);
    expect_v("idle_wb_busy",       S_BUSY, 32'd0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_generation_sequencer
